// File: rtl/alu_pkg.sv
// Definitions shared by the ALU and the units that drive it: datapath width and 3-bit op codes.
package alu_pkg;
    localparam int WIDTH = 32;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_NOT  = 3'b100;
    localparam logic [2:0] ALU_SLTU = 3'b101;
endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; the multiply/divide unit borrows it one operation per cycle.
module alu #(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    import alu_pkg::*;

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = num1 + num2;
            ALU_SUB:  result = num1 - num2;
            ALU_AND:  result = num1 & num2;
            ALU_OR:   result = num1 | num2;
            ALU_NOT:  result = ~num1;
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (num1 < num2)};
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);
endmodule

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned shift-add multiplier and restoring divider that time-shares an external ALU.
module alu_iter_muldiv #(
    parameter int WIDTH     = alu_pkg::WIDTH,
    parameter int MUL_STEPS = 32,
    parameter int DIV_STEPS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);
    import alu_pkg::*;

    localparam int MAX_STEPS = (MUL_STEPS > DIV_STEPS) ? MUL_STEPS : DIV_STEPS;
    localparam int STEP_W    = $clog2(MAX_STEPS) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DCMP,
        S_DSUB,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  hi_acc;     // mul: upper partial product; div: remainder
    logic [WIDTH-1:0]  lo_acc;     // mul: lower partial product; div: quotient
    logic [WIDTH-1:0]  mplier;
    logic [WIDTH-1:0]  operand;    // mul: multiplicand; div: divisor
    logic              rem_msb;
    logic              ge_q;

    logic              mul_last;
    logic              div_last;
    logic              mul_carry;
    logic [WIDTH-1:0]  mul_sum;
    logic [WIDTH-1:0]  mul_hi_nx;
    logic [WIDTH-1:0]  mul_lo_nx;
    logic [WIDTH-1:0]  rem_nx;
    logic [WIDTH-1:0]  quo_nx;

    // The zero flag is redundant with the result compare done here.
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;

    assign mul_last = (step == STEP_W'(MUL_STEPS - 1));
    assign div_last = (step == STEP_W'(DIV_STEPS - 1));

    assign mul_sum   = mplier[0] ? alu_result : hi_acc;
    assign mul_carry = mplier[0] & (alu_result < hi_acc);
    assign mul_hi_nx = {mul_carry, mul_sum[WIDTH-1:1]};
    assign mul_lo_nx = {mul_sum[0], lo_acc[WIDTH-1:1]};

    assign rem_nx = ge_q ? alu_result : hi_acc;
    assign quo_nx = {lo_acc[WIDTH-1:1], ge_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            step    <= '0;
            hi_acc  <= '0;
            lo_acc  <= '0;
            mplier  <= '0;
            operand <= '0;
            rem_msb <= 1'b0;
            ge_q    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        step    <= '0;
                        ge_q    <= 1'b0;
                        rem_msb <= 1'b0;
                        hi_acc  <= '0;
                        lo_acc  <= '0;
                        if (!is_div) begin
                            operand <= a;
                            mplier  <= b;
                        end else if (b == '0) begin
                            hi <= a;
                            lo <= '1;
                        end else begin
                            // First dividend bit is shifted in on the way into DCMP.
                            operand <= b;
                            hi_acc  <= {{(WIDTH-1){1'b0}}, a[WIDTH-1]};
                            lo_acc  <= {a[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                S_MUL: begin
                    hi_acc <= mul_hi_nx;
                    lo_acc <= mul_lo_nx;
                    mplier <= mplier >> 1;
                    step   <= step + STEP_W'(1);
                    if (mul_last) begin
                        hi <= mul_hi_nx;
                        lo <= mul_lo_nx;
                    end
                end
                S_DCMP: begin
                    ge_q <= rem_msb | (alu_result == '0);
                end
                S_DSUB: begin
                    step <= step + STEP_W'(1);
                    if (div_last) begin
                        hi <= rem_nx;
                        lo <= quo_nx;
                    end else begin
                        rem_msb <= rem_nx[WIDTH-1];
                        hi_acc  <= {rem_nx[WIDTH-2:0], quo_nx[WIDTH-1]};
                        lo_acc  <= {quo_nx[WIDTH-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        alu_op   = ALU_ADD;
        alu_a    = '0;
        alu_b    = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (!is_div)
                        state_nx = S_MUL;
                    else if (b == '0)
                        state_nx = S_DONE;
                    else
                        state_nx = S_DCMP;
                end
            end
            S_MUL: begin
                alu_a = hi_acc;
                alu_b = operand;
                if (mul_last)
                    state_nx = S_DONE;
            end
            S_DCMP: begin
                alu_op   = ALU_SLTU;
                alu_a    = hi_acc;
                alu_b    = operand;
                state_nx = S_DSUB;
            end
            S_DSUB: begin
                alu_a = hi_acc;
                if (ge_q) begin
                    alu_op = ALU_SUB;
                    alu_b  = operand;
                end
                state_nx = div_last ? S_DONE : S_DCMP;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy = (state == S_MUL) || (state == S_DCMP) || (state == S_DSUB);
    assign done = (state == S_DONE);
endmodule
